// File: rtl/store_buffer.sv
// In-order store buffer: queues committed stores, drains them over the dmem_w handshake
// and flags overlapping loads. Macro STORE_BUFFER_ADDR_CHECK_EN enables per-entry address checking.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DADDRW = 32,
  parameter int DDATAW = 64,
  parameter int DSIZEW = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [DADDRW-1:0]        st_address,
  input  logic [DDATAW-1:0]        st_data,
  input  logic [DSIZEW-1:0]        st_size,
  output logic                     dmem_w_valid,
  input  logic                     dmem_w_ready,
  output logic [DADDRW-1:0]        dmem_w_address,
  output logic                     dmem_w_wr_en,
  output logic [DDATAW-1:0]        dmem_w_wr_data,
  output logic [DSIZEW-1:0]        dmem_w_wr_size,
  input  logic [DADDRW-1:0]        ld_check_address,
  input  logic [DSIZEW-1:0]        ld_check_size,
  output logic                     ld_conflict,
  output logic                     sb_empty,
  output logic                     sb_full,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [DADDRW-1:0] addr_mem_q [DEPTH];
  logic [DADDRW-1:0] addr_mem_d [DEPTH];
  logic [DDATAW-1:0] data_mem_q [DEPTH];
  logic [DDATAW-1:0] data_mem_d [DEPTH];
  logic [DSIZEW-1:0] size_mem_q [DEPTH];
  logic [DSIZEW-1:0] size_mem_d [DEPTH];

  logic push;
  logic pop;

  assign sb_count     = count_q;
  assign sb_empty     = (count_q == '0);
  assign sb_full      = (count_q == CNTW'(DEPTH));
  // A full buffer never accepts, even while popping: no pass-through path.
  assign st_ready     = !sb_full && !reset;
  assign dmem_w_valid = !sb_empty;
  assign dmem_w_wr_en = dmem_w_valid;
  assign push         = st_valid && st_ready;
  assign pop          = dmem_w_valid && dmem_w_ready;

  assign dmem_w_address = sb_empty ? '0 : addr_mem_q[rd_ptr_q];
  assign dmem_w_wr_data = sb_empty ? '0 : data_mem_q[rd_ptr_q];
  assign dmem_w_wr_size = sb_empty ? '0 : size_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    size_mem_d = size_mem_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push) begin
      addr_mem_d[wr_ptr_q] = st_address;
      data_mem_d[wr_ptr_q] = st_data;
      size_mem_d[wr_ptr_q] = st_size;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
    size_mem_q <= size_mem_d;
  end

`ifdef STORE_BUFFER_ADDR_CHECK_EN
  localparam int SUMW = DADDRW + 1;

  // One extra bit so base+size never wraps; ranges are half-open [base, base+size).
  function automatic logic ranges_overlap(
    input logic [DADDRW-1:0] a_addr,
    input logic [DSIZEW-1:0] a_size,
    input logic [DADDRW-1:0] b_addr,
    input logic [DSIZEW-1:0] b_size
  );
    logic [SUMW-1:0] a_lo, a_hi, b_lo, b_hi;
    a_lo = {1'b0, a_addr};
    b_lo = {1'b0, b_addr};
    a_hi = a_lo + SUMW'(a_size);
    b_hi = b_lo + SUMW'(b_size);
    return (a_lo < b_hi) && (b_lo < a_hi);
  endfunction

  logic [PTRW-1:0] slot_offset;

  always_comb begin
    slot_offset = '0;
    ld_conflict = push && ranges_overlap(st_address, st_size, ld_check_address, ld_check_size);
    for (int i = 0; i < DEPTH; i++) begin
      // Slot i is occupied when its distance from the head is below the count.
      slot_offset = PTRW'(i) - rd_ptr_q;
      if (({1'b0, slot_offset} < count_q) &&
          ranges_overlap(addr_mem_q[i], size_mem_q[i], ld_check_address, ld_check_size)) begin
        ld_conflict = 1'b1;
      end
    end
  end
`else
  logic unused_ld_check;
  assign unused_ld_check = ^{ld_check_address, ld_check_size};
  assign ld_conflict     = !sb_empty || push;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue scoreboard of accepted stores plus
// directed checks of fill, backpressure, simultaneous push/pop, load conflicts and reset.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_address;
  logic [63:0] st_data;
  logic [3:0]  st_size;
  logic        dmem_w_valid;
  logic        dmem_w_ready;
  logic [31:0] dmem_w_address;
  logic        dmem_w_wr_en;
  logic [63:0] dmem_w_wr_data;
  logic [3:0]  dmem_w_wr_size;
  logic [31:0] ld_check_address;
  logic [3:0]  ld_check_size;
  logic        ld_conflict;
  logic        sb_empty;
  logic        sb_full;
  logic [2:0]  sb_count;

  store_buffer #(.DEPTH(DEPTH), .DADDRW(32), .DDATAW(64), .DSIZEW(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_address(st_address),
    .st_data(st_data), .st_size(st_size),
    .dmem_w_valid(dmem_w_valid), .dmem_w_ready(dmem_w_ready),
    .dmem_w_address(dmem_w_address), .dmem_w_wr_en(dmem_w_wr_en),
    .dmem_w_wr_data(dmem_w_wr_data), .dmem_w_wr_size(dmem_w_wr_size),
    .ld_check_address(ld_check_address), .ld_check_size(ld_check_size),
    .ld_conflict(ld_conflict), .sb_empty(sb_empty), .sb_full(sb_full),
    .sb_count(sb_count)
  );

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
    logic [3:0]  s;
  } st_t;

  st_t sbq[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_push   = 0;

  logic        obs_ready, obs_valid, obs_conf, obs_empty, obs_full;
  logic [31:0] obs_addr;
  logic [63:0] obs_data;
  logic [3:0]  obs_size;
  logic [2:0]  obs_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ovl(input logic [31:0] a, input logic [3:0] as,
                               input logic [31:0] b, input logic [3:0] bs);
    logic [32:0] a_end, b_end;
    a_end = {1'b0, a} + {29'd0, as};
    b_end = {1'b0, b} + {29'd0, bs};
    return ({1'b0, a} < b_end) && ({1'b0, b} < a_end);
  endfunction

  // One clock: check outputs at the falling edge, then update the model at the rising edge.
  task automatic cycle();
    logic push, pop, exp_conf;
    int   cnt;
    @(negedge clk);
    cnt  = sbq.size();
    push = st_valid && !reset && (cnt < DEPTH);
    pop  = (cnt > 0) && dmem_w_ready;
    check("st_ready", st_ready, !reset && (cnt < DEPTH));
    check("w_valid", dmem_w_valid, cnt != 0);
    check("w_wr_en", dmem_w_wr_en, cnt != 0);
    check("sb_count", sb_count, cnt);
    check("sb_empty", sb_empty, cnt == 0);
    check("sb_full", sb_full, cnt == DEPTH);
    if (cnt != 0) begin
      check("w_address", dmem_w_address, sbq[0].a);
      check("w_data", dmem_w_wr_data, sbq[0].d);
      check("w_size", dmem_w_wr_size, sbq[0].s);
    end else begin
      check("w_address_zero", dmem_w_address, 0);
      check("w_data_zero", dmem_w_wr_data, 0);
      check("w_size_zero", dmem_w_wr_size, 0);
    end
`ifdef STORE_BUFFER_ADDR_CHECK_EN
    exp_conf = push && ovl(st_address, st_size, ld_check_address, ld_check_size);
    foreach (sbq[k])
      if (ovl(sbq[k].a, sbq[k].s, ld_check_address, ld_check_size)) exp_conf = 1'b1;
`else
    exp_conf = (cnt != 0) || push;
`endif
    check("ld_conflict", ld_conflict, exp_conf);
    obs_ready = st_ready;       obs_valid = dmem_w_valid; obs_conf = ld_conflict;
    obs_empty = sb_empty;       obs_full  = sb_full;      obs_count = sb_count;
    obs_addr  = dmem_w_address; obs_data  = dmem_w_wr_data; obs_size = dmem_w_wr_size;
    @(posedge clk);
    if (reset) begin
      sbq.delete();
    end else begin
      if (pop) void'(sbq.pop_front());
      if (push) begin
        sbq.push_back('{a: st_address, d: st_data, s: st_size});
        n_push++;
      end
    end
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [63:0] d, input logic [3:0] s);
    st_valid = 1'b1; st_address = a; st_data = d; st_size = s;
  endtask

  task automatic drain(input int max_cycles);
    st_valid = 1'b0; dmem_w_ready = 1'b1;
    for (int i = 0; i < max_cycles && sbq.size() > 0; i++) cycle();
    check("drained", sbq.size(), 0);
  endtask

  initial begin
    int base;
    reset = 1'b1; st_valid = 1'b0; st_address = '0; st_data = '0; st_size = '0;
    dmem_w_ready = 1'b0; ld_check_address = 32'h0000_9000; ld_check_size = 4'd4;

    // Reset state
    @(posedge clk); #1;
    cycle();
    check("ready_in_reset", obs_ready, 0);
    reset = 1'b0;
    cycle();
    check("ready_after_reset", obs_ready, 1);
    check("empty_after_reset", obs_empty, 1);

    // Single store with one-cycle latency
    dmem_w_ready = 1'b1;
    drive_store(32'h0000_1000, 64'h1122_3344_5566_7788, 4'd8);
    cycle();
    check("single_no_bypass", obs_valid, 0);
    st_valid = 1'b0;
    cycle();
    check("single_valid", obs_valid, 1);
    check("single_addr", obs_addr, 32'h0000_1000);
    check("single_data", obs_data, 64'h1122_3344_5566_7788);
    check("single_size", obs_size, 8);
    cycle();
    check("single_empty_after", obs_empty, 1);

    // Fill under backpressure, fifth store waits for the first pop
    dmem_w_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_store(32'h0000_4000 + k * 8, 64'hA000_0000_0000_0000 + k, 4'd8);
      cycle();
    end
    drive_store(32'h0000_4020, 64'hA000_0000_0000_0004, 4'd4);
    cycle();
    check("fill_full", obs_full, 1);
    check("fill_not_ready", obs_ready, 0);
    dmem_w_ready = 1'b1;
    cycle();
    check("full_pop_no_accept", obs_ready, 0);
    cycle();
    check("fifth_accepted", obs_ready, 1);
    check("fifth_head_order", obs_data, 64'hA000_0000_0000_0001);
    drain(10);
    check("total_pushes", n_push, 6);

    // Simultaneous push and pop at count 2
    dmem_w_ready = 1'b0;
    drive_store(32'h0000_6000, 64'h0000_0000_0000_00C0, 4'd1); cycle();
    drive_store(32'h0000_6001, 64'h0000_0000_0000_00C1, 4'd1); cycle();
    dmem_w_ready = 1'b1;
    drive_store(32'h0000_6002, 64'h0000_0000_0000_00C2, 4'd2); cycle();
    check("pp_count_before", obs_count, 2);
    drive_store(32'h0000_6004, 64'h0000_0000_0000_00C3, 4'd4); cycle();
    check("pp_count_held", obs_count, 2);
    check("pp_order", obs_data, 64'h0000_0000_0000_00C1);
    drain(10);

`ifdef STORE_BUFFER_ADDR_CHECK_EN
    dmem_w_ready = 1'b0;
    drive_store(32'h0000_2004, 64'h0000_0000_DEAD_BEEF, 4'd4); cycle();
    st_valid = 1'b0;
    ld_check_address = 32'h0000_2006; ld_check_size = 4'd2; cycle();
    check("conf_2006_2", obs_conf, 1);
    ld_check_address = 32'h0000_2008; ld_check_size = 4'd4; cycle();
    check("conf_2008_4", obs_conf, 0);
    ld_check_address = 32'h0000_2000; ld_check_size = 4'd8; cycle();
    check("conf_2000_8", obs_conf, 1);
    ld_check_address = 32'h0000_3000; ld_check_size = 4'd4; cycle();
    check("conf_3000_nopush", obs_conf, 0);
    drive_store(32'h0000_3000, 64'h0000_0000_0000_0033, 4'd4); cycle();
    check("conf_3000_push", obs_conf, 1);
    drain(10);
`else
    dmem_w_ready = 1'b0;
    drive_store(32'h0000_2004, 64'h0000_0000_DEAD_BEEF, 4'd4); cycle();
    st_valid = 1'b0;
    ld_check_address = 32'h0000_7000; ld_check_size = 4'd1; cycle();
    check("cons_count1", obs_count, 1);
    check("cons_conf_pending", obs_conf, 1);
    drain(10);
    cycle();
    check("cons_conf_empty", obs_conf, 0);
`endif

    // Reset with three entries queued
    dmem_w_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_store(32'h0000_8000 + k * 4, 64'hB000_0000_0000_0000 + k, 4'd4);
      cycle();
    end
    reset = 1'b1;
    drive_store(32'h0000_8F00, 64'hBAD0_0000_0000_0000, 4'd8);
    cycle();
    check("rst_mid_ready", obs_ready, 0);
    reset = 1'b0; st_valid = 1'b0;
    cycle();
    check("rst_mid_count", obs_count, 0);
    check("rst_mid_valid", obs_valid, 0);
    check("rst_mid_ready_after", obs_ready, 1);
    dmem_w_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      base = $urandom_range(0, 31);
      st_valid = ($urandom_range(0, 2) != 0);
      st_address = 32'h0000_5000 + base;
      st_data = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: st_size = 4'd1;
        1: st_size = 4'd2;
        2: st_size = 4'd4;
        default: st_size = 4'd8;
      endcase
      dmem_w_ready = ($urandom_range(0, 2) == 0);
      ld_check_address = 32'h0000_5000 + $urandom_range(0, 39);
      ld_check_size = 4'd1 << $urandom_range(0, 3);
      cycle();
    end
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
